// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : switch_allocator
//  Description : Separable input-first switch allocator. Each input port
//                picks one eligible VC (round-robin), then each output port
//                picks one of the input ports targeting it (round-robin).
//                Grants are registered and drive the input VC select and
//                the crossbar select of the switch traversal stage.
//                Optional feature macro: SA_SWITCH_LOCK_EN (wormhole switch
//                locking of an output to one input VC until its tail flit).
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_allocator #(
    parameter int PORT_NUM  = 5,
    parameter int VC_NUM    = 4,
    parameter int VC_SIZE   = $clog2(VC_NUM),
    parameter int PORT_SIZE = $clog2(PORT_NUM)
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]              request_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]              on_off_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]              is_tail_i,
    output logic [PORT_NUM-1:0]                          valid_sel_o,
    output logic [PORT_NUM-1:0][VC_SIZE-1:0]             vc_sel_o,
    output logic [PORT_NUM-1:0]                          xbar_valid_o,
    output logic [PORT_NUM-1:0][PORT_SIZE-1:0]           xbar_sel_o
);

    logic [PORT_NUM-1:0][VC_NUM-1:0]    w_elig;
    logic [PORT_NUM-1:0]                w_force_valid;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   w_force_vc;
    logic [PORT_NUM-1:0]                w_s1_valid;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   w_s1_vc;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] w_s1_port;
    logic [PORT_NUM-1:0]                w_out_gnt;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] w_out_sel;
    logic [PORT_NUM-1:0]                w_in_gnt;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   r_in_ptr;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] r_out_ptr;

`ifdef SA_SWITCH_LOCK_EN
    logic [PORT_NUM-1:0]                r_lock;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] r_lock_in;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   r_lock_vc;
`endif

    // Eligibility: request present and the assigned downstream VC is "on"
    for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_in
        for (genvar gv = 0; gv < VC_NUM; gv++) begin : g_vc
            logic [PORT_SIZE-1:0] w_op;
            logic [VC_SIZE-1:0]   w_dvc;
            logic                 w_raw;
            assign w_op  = out_port_i[gi][gv];
            assign w_dvc = downstream_vc_i[gi][gv];
            // Out-of-range output codes can never be granted
            assign w_raw = request_i[gi][gv] && (int'(w_op) < PORT_NUM)
                           && on_off_i[w_op][w_dvc];
`ifdef SA_SWITCH_LOCK_EN
            logic w_blocked;
            // A locked output only accepts its owning input VC
            assign w_blocked = r_lock[w_op] &&
                               !((r_lock_in[w_op] == PORT_SIZE'(gi)) &&
                                 (r_lock_vc[w_op] == VC_SIZE'(gv)));
            assign w_elig[gi][gv] = w_raw && !w_blocked;
`else
            assign w_elig[gi][gv] = w_raw;
`endif
        end
    end

`ifdef SA_SWITCH_LOCK_EN
    // Lock owners that are eligible override input round-robin (lowest output wins ties)
    always_comb begin
        w_force_valid = '0;
        w_force_vc    = '0;
        for (int o = PORT_NUM - 1; o >= 0; o--) begin
            if (r_lock[o] && w_elig[r_lock_in[o]][r_lock_vc[o]]) begin
                w_force_valid[r_lock_in[o]] = 1'b1;
                w_force_vc[r_lock_in[o]]    = r_lock_vc[o];
            end
        end
    end
`else
    assign w_force_valid = '0;
    assign w_force_vc    = '0;

    logic w_unused_tail;
    assign w_unused_tail = ^is_tail_i;
`endif

    // Stage 1: per-input round-robin over eligible VCs starting at r_in_ptr
    always_comb begin
        w_s1_valid = '0;
        w_s1_vc    = '0;
        w_s1_port  = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            // Descending scan so the closest VC to the pointer is assigned last
            for (int k = VC_NUM - 1; k >= 0; k--) begin
                int idx;
                idx = int'(r_in_ptr[i]) + k;
                if (idx >= VC_NUM) idx = idx - VC_NUM;
                if (w_elig[i][VC_SIZE'(idx)]) begin
                    w_s1_valid[i] = 1'b1;
                    w_s1_vc[i]    = VC_SIZE'(idx);
                end
            end
            if (w_force_valid[i]) begin
                w_s1_valid[i] = 1'b1;
                w_s1_vc[i]    = w_force_vc[i];
            end
            w_s1_port[i] = out_port_i[i][w_s1_vc[i]];
        end
    end

    // Stage 2: per-output round-robin over stage-1 winners starting at r_out_ptr
    always_comb begin
        w_out_gnt = '0;
        w_out_sel = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int k = PORT_NUM - 1; k >= 0; k--) begin
                int idx;
                idx = int'(r_out_ptr[o]) + k;
                if (idx >= PORT_NUM) idx = idx - PORT_NUM;
                if (w_s1_valid[PORT_SIZE'(idx)] &&
                    (w_s1_port[PORT_SIZE'(idx)] == PORT_SIZE'(o))) begin
                    w_out_gnt[o] = 1'b1;
                    w_out_sel[o] = PORT_SIZE'(idx);
                end
            end
        end
    end

    // Map output grants back to the winning input ports
    always_comb begin
        w_in_gnt = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            if (w_out_gnt[o]) w_in_gnt[w_out_sel[o]] = 1'b1;
        end
    end

    // Registered grants and round-robin pointers; selects hold when not granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_sel_o  <= '0;
            vc_sel_o     <= '0;
            xbar_valid_o <= '0;
            xbar_sel_o   <= '0;
            r_in_ptr     <= '0;
            r_out_ptr    <= '0;
        end else begin
            for (int i = 0; i < PORT_NUM; i++) begin
                valid_sel_o[i] <= w_in_gnt[i];
                if (w_in_gnt[i]) begin
                    vc_sel_o[i] <= w_s1_vc[i];
                    r_in_ptr[i] <= (int'(w_s1_vc[i]) == VC_NUM - 1) ? '0
                                   : w_s1_vc[i] + 1'b1;
                end
            end
            for (int o = 0; o < PORT_NUM; o++) begin
                xbar_valid_o[o] <= w_out_gnt[o];
                if (w_out_gnt[o]) begin
                    xbar_sel_o[o] <= w_out_sel[o];
                    r_out_ptr[o]  <= (int'(w_out_sel[o]) == PORT_NUM - 1) ? '0
                                     : w_out_sel[o] + 1'b1;
                end
            end
        end
    end

`ifdef SA_SWITCH_LOCK_EN
    // Lock an output on a non-tail grant, release it on the owner's tail grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock    <= '0;
            r_lock_in <= '0;
            r_lock_vc <= '0;
        end else begin
            for (int o = 0; o < PORT_NUM; o++) begin
                if (w_out_gnt[o]) begin
                    r_lock[o]    <= !is_tail_i[w_out_sel[o]][w_s1_vc[w_out_sel[o]]];
                    r_lock_in[o] <= w_out_sel[o];
                    r_lock_vc[o] <= w_s1_vc[w_out_sel[o]];
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_allocator
//  Description : Self-checking bench for switch_allocator: directed scenarios
//                plus randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_allocator;
    localparam int PN = 5, VN = 4, VS = 2, PS = 3;
    localparam int LOCAL = 0, NORTH = 1, SOUTH = 2, WEST = 3, EAST = 4;

    logic clk = 1'b0;
    logic rst;
    logic [PN-1:0][VN-1:0]         request, on_off, is_tail;
    logic [PN-1:0][VN-1:0][PS-1:0] out_port;
    logic [PN-1:0][VN-1:0][VS-1:0] dvc;
    logic [PN-1:0]                 valid_sel, xbar_valid;
    logic [PN-1:0][VS-1:0]         vc_sel;
    logic [PN-1:0][PS-1:0]         xbar_sel;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_in_ptr[PN], m_out_ptr[PN];
    bit m_lock[PN];
    int m_lock_in[PN], m_lock_vc[PN];
    logic [PN-1:0] e_valid_sel, e_xbar_valid;
    int e_vc_sel[PN], e_xbar_sel[PN];

    always #5 clk = ~clk;

    switch_allocator #(.PORT_NUM(PN), .VC_NUM(VN), .VC_SIZE(VS), .PORT_SIZE(PS)) dut (
        .clk(clk), .rst(rst),
        .request_i(request), .out_port_i(out_port), .downstream_vc_i(dvc),
        .on_off_i(on_off), .is_tail_i(is_tail),
        .valid_sel_o(valid_sel), .vc_sel_o(vc_sel),
        .xbar_valid_o(xbar_valid), .xbar_sel_o(xbar_sel)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < PN; p++) begin
            m_in_ptr[p] = 0; m_out_ptr[p] = 0; m_lock[p] = 0;
            m_lock_in[p] = 0; m_lock_vc[p] = 0;
            e_vc_sel[p] = 0; e_xbar_sel[p] = 0;
        end
        e_valid_sel = '0;
        e_xbar_valid = '0;
    endtask

    // Predict the grant of the coming edge from current inputs, then advance state
    task automatic model_cycle();
        bit elig[PN][VN];
        bit s1v[PN];
        int s1vc[PN];
        for (int i = 0; i < PN; i++)
            for (int v = 0; v < VN; v++) begin
                int op;
                op = int'(out_port[i][v]);
                elig[i][v] = request[i][v] && (op < PN) && on_off[op][dvc[i][v]];
            end
`ifdef SA_SWITCH_LOCK_EN
        for (int o = 0; o < PN; o++)
            if (m_lock[o])
                for (int i = 0; i < PN; i++)
                    for (int v = 0; v < VN; v++)
                        if (int'(out_port[i][v]) == o && !(i == m_lock_in[o] && v == m_lock_vc[o]))
                            elig[i][v] = 0;
`endif
        for (int i = 0; i < PN; i++) begin
            s1v[i] = 0; s1vc[i] = 0;
`ifdef SA_SWITCH_LOCK_EN
            for (int o = 0; o < PN; o++)
                if (!s1v[i] && m_lock[o] && m_lock_in[o] == i && elig[i][m_lock_vc[o]]) begin
                    s1v[i] = 1; s1vc[i] = m_lock_vc[o];
                end
`endif
            for (int k = 0; k < VN; k++) begin
                int v;
                v = (m_in_ptr[i] + k) % VN;
                if (!s1v[i] && elig[i][v]) begin s1v[i] = 1; s1vc[i] = v; end
            end
        end
        e_valid_sel = '0;
        e_xbar_valid = '0;
        for (int o = 0; o < PN; o++) begin
            int won;
            won = -1;
            for (int k = 0; k < PN; k++) begin
                int i;
                i = (m_out_ptr[o] + k) % PN;
                if (won < 0 && s1v[i] && int'(out_port[i][s1vc[i]]) == o) won = i;
            end
            if (won >= 0) begin
                e_xbar_valid[o] = 1'b1;
                e_xbar_sel[o]   = won;
                e_valid_sel[won] = 1'b1;
                e_vc_sel[won]   = s1vc[won];
                m_in_ptr[won]   = (s1vc[won] + 1) % VN;
                m_out_ptr[o]    = (won + 1) % PN;
                m_lock[o]       = !is_tail[won][s1vc[won]];
                m_lock_in[o]    = won;
                m_lock_vc[o]    = s1vc[won];
            end
        end
    endtask

    task automatic compare_all();
        check("valid_sel", 32'(valid_sel), 32'(e_valid_sel));
        check("xbar_valid", 32'(xbar_valid), 32'(e_xbar_valid));
        for (int p = 0; p < PN; p++) begin
            check($sformatf("vc_sel[%0d]", p), 32'(vc_sel[p]), e_vc_sel[p]);
            check($sformatf("xbar_sel[%0d]", p), 32'(xbar_sel[p]), e_xbar_sel[p]);
        end
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        request = '0; out_port = '0; dvc = '0; on_off = '1; is_tail = '1;
    endtask

    int conflict_seq[6] = '{0, 2, 3, 0, 2, 3};
`ifdef SA_SWITCH_LOCK_EN
    int lock_seq[5] = '{1, 1, 1, 1, 2};
`else
    int lock_seq[5] = '{1, 2, 1, 2, 1};
`endif

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
        step();

        // Single request: input 1 VC 2 to EAST
        request[1][2] = 1'b1; out_port[1][2] = PS'(EAST); dvc[1][2] = '0;
        step();
        check("single_valid_sel", 32'(valid_sel), 32'h02);
        check("single_vc_sel", 32'(vc_sel[1]), 2);
        check("single_xbar_valid", 32'(xbar_valid), 32'h10);
        check("single_xbar_sel", 32'(xbar_sel[EAST]), 1);
        clear_inputs(); step();

        // Output conflict: inputs 0, 2, 3 all want NORTH
        request[0][0] = 1'b1; out_port[0][0] = PS'(NORTH);
        request[2][0] = 1'b1; out_port[2][0] = PS'(NORTH);
        request[3][0] = 1'b1; out_port[3][0] = PS'(NORTH);
        for (int k = 0; k < 6; k++) begin
            step();
            check("conflict_sel", 32'(xbar_sel[NORTH]), conflict_seq[k]);
            check("conflict_valid", 32'(xbar_valid), 32'h02);
        end
        clear_inputs(); step();

        // Input VC fairness: input 4 VC0->WEST, VC1->SOUTH
        request[4][0] = 1'b1; out_port[4][0] = PS'(WEST);
        request[4][1] = 1'b1; out_port[4][1] = PS'(SOUTH);
        for (int k = 0; k < 4; k++) begin
            step();
            check("fair_vc_sel", 32'(vc_sel[4]), k % 2);
        end
        clear_inputs(); step();

        // Flow control: downstream VC off for 3 cycles
        request[2][1] = 1'b1; out_port[2][1] = PS'(EAST); dvc[2][1] = 2'd3;
        on_off[EAST][3] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("flow_hold", 32'(valid_sel), 0);
        end
        on_off[EAST][3] = 1'b1;
        step();
        check("flow_grant", 32'(valid_sel[2]), 1);
        check("flow_vc", 32'(vc_sel[2]), 1);
        clear_inputs(); step();

        // Asynchronous reset mid-stream
        request[4] = 4'b1111;
        out_port[4][0] = PS'(LOCAL); out_port[4][1] = PS'(NORTH);
        out_port[4][2] = PS'(WEST);  out_port[4][3] = PS'(EAST);
        step();
        check("pre_rst_vc", 32'(vc_sel[4]), 2);
        #2 rst = 1'b1;
        #1;
        check("rst_valid_sel", 32'(valid_sel), 0);
        check("rst_vc_sel", 32'(vc_sel), 0);
        check("rst_xbar_valid", 32'(xbar_valid), 0);
        check("rst_xbar_sel", 32'(xbar_sel), 0);
        model_reset();
        #1 rst = 1'b0;
        step();
        check("post_rst_vc", 32'(vc_sel[4]), 0);
        check("post_rst_valid", 32'(valid_sel[4]), 1);
        clear_inputs(); step();

        // Packet of 4 flits from (1,0) to SOUTH against (2,0)
        request[1][0] = 1'b1; out_port[1][0] = PS'(SOUTH);
        request[2][0] = 1'b1; out_port[2][0] = PS'(SOUTH);
        for (int k = 0; k < 5; k++) begin
            is_tail[1][0] = (k == 3);
            step();
            check("lock_sel", 32'(xbar_sel[SOUTH]), lock_seq[k]);
            check("lock_valid", 32'(xbar_valid[SOUTH]), 1);
        end
        clear_inputs(); step();

        // Randomized traffic with occasional asynchronous reset
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < PN; i++)
                for (int v = 0; v < VN; v++) begin
                    request[i][v]  = ($urandom_range(0, 1) == 1);
                    out_port[i][v] = PS'($urandom_range(0, PN - 1));
                    dvc[i][v]      = VS'($urandom_range(0, VN - 1));
                    on_off[i][v]   = ($urandom_range(0, 3) != 0);
                    is_tail[i][v]  = ($urandom_range(0, 2) == 0);
                end
            step();
            if ($urandom_range(0, 49) == 0) begin
                #2 rst = 1'b1;
                #1;
                model_reset();
                compare_all();
                #1 rst = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/switch_allocator.md
# switch_allocator

Separable input-first switch allocator for the mesh router. Each cycle it picks at most one requesting VC per input port and at most one input port per output port, using round-robin arbitration at both stages. A request is eligible only when the downstream VC assigned during VA is signalling "on". Grants are registered. They drive each input port's `vc_sel_i`/`valid_sel_i` and the crossbar select for the switch traversal stage.

## Interface
Parameters:
- `PORT_NUM`, default 5: number of router ports (LOCAL, NORTH, SOUTH, WEST, EAST), equal at input and output.
- `VC_NUM`, default from `noc_params`: number of VCs per input port.
- `VC_SIZE`, default from `noc_params`: VC index width.
- `PORT_SIZE`, default `$clog2(PORT_NUM)`: port index width.

Ports:
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst`, input, 1: asynchronous reset, active-high.
- `request_i`, input, `[PORT_NUM][VC_NUM]`: per-input-VC SA request. This is the input port's non-empty and VA-done status.
- `out_port_i`, input, `port_t [PORT_NUM][VC_NUM]`: output port computed by RC for each input VC.
- `downstream_vc_i`, input, `[PORT_NUM][VC_NUM][VC_SIZE]`: downstream VC assigned by VA for each input VC.
- `on_off_i`, input, `[PORT_NUM][VC_NUM]`: per-output-port, per-downstream-VC on/off flow-control bit. 1 means the flit may be sent.
- `is_tail_i`, input, `[PORT_NUM][VC_NUM]`: the head-of-buffer flit of that VC is TAIL or HEADTAIL. Used only with `SA_SWITCH_LOCK_EN`.
- `valid_sel_o`, output, `[PORT_NUM]`: per input port, a flit is to be read this cycle.
- `vc_sel_o`, output, `[PORT_NUM][VC_SIZE]`: per input port, the VC to read.
- `xbar_valid_o`, output, `[PORT_NUM]`: per output port, the crossbar output is valid.
- `xbar_sel_o`, output, `[PORT_NUM][PORT_SIZE]`: per output port, the selected input port index.

## Operation
- Eligibility: `elig[i][v] = request_i[i][v] & on_off_i[out_port_i[i][v]][downstream_vc_i[i][v]]`.
- Stage 1 (per input port `i`):
  - Round-robin over `elig[i][*]`, starting at `in_ptr[i]`; the first eligible VC at or after the pointer, wrapping modulo `VC_NUM`, wins.
  - Produces `s1_valid[i]`, `s1_vc[i]` and `s1_port[i] = out_port_i[i][s1_vc[i]]`.
- Stage 2 (per output port `o`):
  - Round-robin over inputs `i` with `s1_valid[i] & s1_port[i]==o`, starting at `out_ptr[o]`.
  - The winner gets the grant.
- An input port that loses stage 2 gets no grant this cycle. There is no second iteration.
- Pointer update happens on grant only:
  - `in_ptr[i] <= (granted_vc+1) mod VC_NUM`.
  - `out_ptr[o] <= (granted_input+1) mod PORT_NUM`.
  - Non-granted pointers hold.
- At most one grant per input port and one per output port per cycle; this is the crossbar-conflict invariant.
- If no request is eligible, the cycle is idle: all valids 0 and pointers unchanged.

## Timing
- The allocation decision is combinational from the inputs; outputs are registered. A request sampled at edge N produces its grant visible after edge N.
  - `valid_sel_o[i]=1`, `vc_sel_o[i]=v`, `xbar_valid_o[o]=1`, `xbar_sel_o[o]=i`.
  - Latency is 1 cycle.
- Grants last one cycle each. A VC still requesting and eligible may be granted on consecutive cycles if it wins again.
- `on_off_i` dropping in the same cycle as a request makes that request ineligible that cycle.
- Reset (asynchronous, mid-operation included):
  - Immediately forces `valid_sel_o=0`, `vc_sel_o=0`, `xbar_valid_o=0`, `xbar_sel_o=0`.
  - All pointers are set to 0 and locks are cleared. The first cycle after release arbitrates from index 0.
- `vc_sel_o` and `xbar_sel_o` hold their last value when the corresponding valid is 0.

## Configuration
- `SA_SWITCH_LOCK_EN` defined: wormhole switch locking.
  - A grant of output `o` to `(i,v)` whose `is_tail_i[i][v]=0` sets `lock[o]` with owner `(i,v)`.
  - While locked, only owner `(i,v)` may win `o`. Stage 1 at input `i` is forced to `v` when `elig[i][v]` is set; requests from other inputs targeting `o` are masked.
  - If the owner is ineligible, `o` idles.
  - The lock clears on the cycle the owner is granted with `is_tail_i=1`.
  - Pointers still update on each grant.
- `SA_SWITCH_LOCK_EN` undefined: per-flit arbitration. `is_tail_i` is ignored and no lock state is instantiated.

## Test plan
- **Single request:** `request_i[1][2]=1`, `out_port=EAST`, downstream VC 0 on. Required: next cycle `valid_sel_o[1]=1`, `vc_sel_o[1]=2`, `xbar_valid_o[EAST]=1`, `xbar_sel_o[EAST]=1`; all other valids 0.
- **Output conflict:** inputs 0, 2 and 3 all request NORTH continuously, each on VC 0 with downstream on. Required: grants rotate 0, 2, 3, 0, ... one per cycle, and never two on NORTH in one cycle.
- **Input VC fairness:** input 4 VCs 0 and 1 request distinct free outputs. Required: alternating grants on `vc_sel_o[4]` of 0, 1, 0, 1.
- **Flow control:** a request with `on_off_i[o][dvc]=0` for 3 cycles, then 1. Required: no grant for 3 cycles, then a grant the cycle after `on_off` rises.
- **Reset mid-stream:** assert `rst` asynchronously between edges while grants are active. Required: all outputs 0 immediately; after release, input arbitration restarts from VC 0.
- **Switch lock (`SA_SWITCH_LOCK_EN`):** (1,0) sends a 4-flit packet to SOUTH while (2,0) also requests SOUTH. Required: (1,0) receives 4 consecutive SOUTH grants through its tail, then (2,0) is granted. Without the macro, grants alternate.
